pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Consumer end of the control-word interface. Takes the PS, PCsel, K, SL and EN_PC fields from the control unit and turns them into program-counter updates, instruction fetch and status-flag storage.
- Fetches instructions from instruction memory with a req/ack handshake. Holds the fetched instruction in an instruction register and presents it to the control unit.
- Returns the registered {V,C,N,Z} and the live zero flag to the control unit as its status input.

Parameters:
- RESET_VECTOR, 64'h0: PC value loaded on reset.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  while high, no new fetch is started.
- imem_req  out  1  fetch request.
- imem_addr  out  64  fetch address; always equals pc.
- imem_ack  in  1  fetch data valid.
- imem_data  in  32  fetched instruction.
- instruction  out  32  instruction register contents, to the control unit.
- instr_valid  out  1  high in the EXEC state.
- PS  in  2  PC select from the control word.
- PCsel  in  1  absolute-target source: 1 = reg_in, 0 = K.
- K  in  64  control-word constant.
- reg_in  in  64  register A bus value.
- SL  in  1  status load.
- EN_PC  in  1  drive PC+4 onto the data bus.
- alu_status  in  4  live ALU {V,C,N,Z}.
- status  out  5  {V,C,N,Z registered, ZZ = live alu_status[0]}.
- pc  out  64  current PC.
- data_out  out  64  PC+4 when data_out_en is high, else 0.
- data_out_en  out  1  EN_PC & instr_valid.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset low, asynchronous; takes effect immediately, including mid-fetch or mid-EXEC):
  - pc = RESET_VECTOR; state = FETCH.
  - instruction = 0; status flags = 0; instr_count = 0.
  - imem_req = 0 while reset is held.
- States: FETCH, EXEC.
- FETCH:
  - imem_req = ~halt.
  - On a clock edge with imem_req & imem_ack: instruction <= imem_data, go to EXEC.
  - imem_ack while imem_req = 0 is ignored.
  - halt rising while a request is outstanding withdraws the request; the PC is unchanged.
- EXEC (instr_valid = 1): exactly one edge per pass. PC update at the edge:
  - PS = 00: pc unchanged, stay in EXEC. The same instruction is re-presented; this supports the two-cycle IW/BL sequences.
  - PS = 01: pc <= pc + 4, go to FETCH.
  - PS = 10: pc <= {target[63:2], 2'b00}, where target = PCsel ? reg_in : K. Go to FETCH.
  - PS = 11: pc <= pc + 4 + (K << 2). K is signed; the sum is a 64-bit two's-complement modulo sum. Go to FETCH.
- Arithmetic: all PC sums wrap modulo 2^64. Example: pc 64'hFFFF_FFFF_FFFF_FFFC with PS = 01 gives 0.
- Status load: if SL & instr_valid at an edge, flags <= alu_status. SL outside EXEC is ignored.
- ZZ: combinational from alu_status[0], never registered. This gives CBZ same-cycle zero detection.
- data_out: pc + 4 combinationally (the pre-update PC) whenever data_out_en = 1; otherwise 0.
- instr_count: increments at each EXEC edge with PS != 00, and wraps at 2^CNT_W.
- halt during EXEC does not stop the current instruction; the next FETCH simply issues no request.
- imem_addr is stable for the whole request; pc changes only at EXEC edges or on reset.

Test Plan:
- Reset, then release with RESET_VECTOR = 0 and imem_ack returning 0x91000421 one cycle after req: imem_addr = 0, instruction = 0x91000421, instr_valid high for one cycle with PS = 01, then pc = 4 and instr_count = 1.
- pc = 0x100, PS = 11, K = -2 (64'hFFFF_FFFF_FFFF_FFFE): next pc = 0x100 + 4 - 8 = 0xFC. Then PS = 10, PCsel = 1, reg_in = 0x2003: pc = 0x2000.
- BL sequence at pc = 0x40: first EXEC edge PS = 00, EN_PC = 1; expect data_out = 0x44, data_out_en = 1, pc held, still EXEC. Second edge PS = 11, K = 4: pc = 0x54, instr_count incremented once.
- Status handling:
  - SL = 1, alu_status = 4'b1010 in EXEC: status[4:1] = 1010 after the edge.
  - SL = 1 in FETCH: flags unchanged.
  - alu_status[0] toggling: status[0] follows in the same cycle.
- Halt and wrap:
  - halt = 1 in FETCH: imem_req = 0 for 5 cycles and pc stable; deassert and the request resumes at the same address.
  - pc = 64'hFFFF_FFFF_FFFF_FFFC, PS = 01: pc = 0.
- Reset low asynchronously mid-EXEC with pc = 0x80: pc = RESET_VECTOR, instr_valid = 0, instruction = 0, instr_count = 0, status = 0 before the next clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch unit: fetches over a req/ack port,
// holds the instruction for the control unit, applies PS-selected PC updates and stores flags.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  output logic              imem_req,
  output logic [63:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic [1:0]        PS,
  input  logic              PCsel,
  input  logic [63:0]       K,
  input  logic [63:0]       reg_in,
  input  logic              SL,
  input  logic              EN_PC,
  input  logic [3:0]        alu_status,
  output logic [4:0]        status,
  output logic [63:0]       pc,
  output logic [63:0]       data_out,
  output logic              data_out_en,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ABS  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // Sequential PC: all sums are plain 64-bit adds, so wrap-around is free.
  function automatic logic [63:0] pc_plus4(input logic [63:0] cur);
    return cur + 64'd4;
  endfunction

  // Absolute target is word aligned by clearing the two low bits.
  function automatic logic [63:0] abs_target(input logic        sel_reg,
                                             input logic [63:0] reg_val,
                                             input logic [63:0] konst);
    logic [63:0] raw;
    raw = sel_reg ? reg_val : konst;
    return raw & ~64'd3;
  endfunction

  // Relative target: signed word offset applied after the PC+4.
  function automatic logic [63:0] rel_target(input logic [63:0] cur,
                                             input logic [63:0] konst);
    return cur + 64'd4 + (konst << 2);
  endfunction

  state_t           state_q,   state_d;
  logic [63:0]      pc_q,      pc_d;
  logic [31:0]      instr_q,   instr_d;
  logic [3:0]       flags_q,   flags_d;
  logic [CNT_W-1:0] count_q,   count_d;

  logic             in_fetch_s;
  logic             in_exec_s;
  logic             fetch_done_s;
  logic [63:0]      pc_inc_s;

  assign in_fetch_s   = (state_q == FETCH);
  assign in_exec_s    = (state_q == EXEC);
  // Gating with reset keeps the request low while reset is held.
  assign imem_req     = reset & in_fetch_s & ~halt;
  assign fetch_done_s = imem_req & imem_ack;
  assign pc_inc_s     = pc_plus4(pc_q);

  // Next-state, PC, instruction, flag and counter computation.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    flags_d = flags_q;
    count_d = count_q;
    case (state_q)
      FETCH: begin
        if (fetch_done_s) begin
          instr_d = imem_data;
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        if (SL) begin
          flags_d = alu_status;
        end else begin
          flags_d = flags_q;
        end
        if (PS != PS_HOLD) begin
          count_d = count_q + CNT_W'(1);
          state_d = FETCH;
        end else begin
          count_d = count_q;
          state_d = EXEC;
        end
        case (PS)
          PS_HOLD: pc_d = pc_q;
          PS_INC:  pc_d = pc_inc_s;
          PS_ABS:  pc_d = abs_target(PCsel, reg_in, K);
          PS_REL:  pc_d = rel_target(pc_q, K);
          default: pc_d = pc_q;
        endcase
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'h0;
      flags_q <= 4'h0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = in_exec_s;
  assign instr_count = count_q;
  // ZZ bypasses the flag register so CBZ sees a zero result in the same cycle.
  assign status      = {flags_q, alu_status[0]};
  assign data_out_en = EN_PC & in_exec_s;
  assign data_out    = data_out_en ? pc_inc_s : 64'h0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: linear stimulus with hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic        halt;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [1:0]  PS;
  logic        PCsel;
  logic [63:0] K;
  logic [63:0] reg_in;
  logic        SL;
  logic        EN_PC;
  logic [3:0]  alu_status;
  logic [4:0]  status;
  logic [63:0] pc;
  logic [63:0] data_out;
  logic        data_out_en;
  logic [31:0] instr_count;

  int n_assert;
  int n_fail;

  pc_fetch_unit #(.RESET_VECTOR(64'h0), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instruction(instruction), .instr_valid(instr_valid),
    .PS(PS), .PCsel(PCsel), .K(K), .reg_in(reg_in), .SL(SL), .EN_PC(EN_PC),
    .alu_status(alu_status), .status(status), .pc(pc),
    .data_out(data_out), .data_out_en(data_out_en), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Completes a fetch from FETCH (request must be up) and checks the IR.
  task automatic fetch(input logic [31:0] word);
    imem_ack  = 1'b1;
    imem_data = word;
    step();
    imem_ack  = 1'b0;
    chk("fetch_valid", {63'd0, instr_valid}, 64'd1);
    chk("fetch_ir", {32'd0, instruction}, {32'd0, word});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    PS = 2'b00; PCsel = 1'b0; K = 64'h0; reg_in = 64'h0;
    SL = 1'b0; EN_PC = 1'b0; alu_status = 4'h0;
    #3;
    chk("rst_pc", pc, 64'h0);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_ir", {32'd0, instruction}, 64'd0);
    chk("rst_cnt", {32'd0, instr_count}, 64'd0);
    chk("rst_status", {59'd0, status}, 64'd0);
    #9 reset = 1'b1;
    step();
    chk("req_after_rst", {63'd0, imem_req}, 64'd1);
    chk("addr_after_rst", imem_addr, 64'h0);
    step();
    chk("wait_no_ack", {63'd0, instr_valid}, 64'd0);
    fetch(32'h9100_0421);
    chk("exec_no_req", {63'd0, imem_req}, 64'd0);
    PS = 2'b01;
    step();
    chk("first_pc", pc, 64'h4);
    chk("first_cnt", {32'd0, instr_count}, 64'd1);
    chk("first_fetch_state", {63'd0, instr_valid}, 64'd0);

    // Halt in FETCH: ack without request is ignored, PC stable.
    halt = 1'b1; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_req", {63'd0, imem_req}, 64'd0);
      chk("halt_pc", pc, 64'h4);
    end
    chk("halt_ack_ignored", {32'd0, instruction}, 64'h9100_0421);
    imem_ack = 1'b0; halt = 1'b0;
    #1;
    chk("resume_req", {63'd0, imem_req}, 64'd1);
    chk("resume_addr", imem_addr, 64'h4);

    fetch(32'h0000_0001);
    PS = 2'b10; PCsel = 1'b0; K = 64'h100;
    step();
    chk("abs_k_pc", pc, 64'h100);
    fetch(32'h0000_0002);
    PS = 2'b11; K = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    chk("rel_neg_pc", pc, 64'hFC);
    fetch(32'h0000_0003);
    PS = 2'b10; PCsel = 1'b1; reg_in = 64'h2003;
    step();
    chk("abs_reg_pc", pc, 64'h2000);
    chk("cnt_4", {32'd0, instr_count}, 64'd4);
    fetch(32'h0000_0004);
    PS = 2'b10; PCsel = 1'b0; K = 64'h40;
    step();
    chk("to_40", pc, 64'h40);

    // BL: hold cycle drives PC+4, then relative branch.
    fetch(32'h9400_0004);
    PS = 2'b00; EN_PC = 1'b1;
    #1;
    chk("bl_data_out", data_out, 64'h44);
    chk("bl_data_en", {63'd0, data_out_en}, 64'd1);
    step();
    chk("bl_pc_held", pc, 64'h40);
    chk("bl_still_exec", {63'd0, instr_valid}, 64'd1);
    chk("bl_cnt_held", {32'd0, instr_count}, 64'd5);
    PS = 2'b11; K = 64'h4; EN_PC = 1'b0;
    #1;
    chk("bl_data_off", data_out, 64'h0);
    step();
    chk("bl_pc", pc, 64'h54);
    chk("bl_cnt", {32'd0, instr_count}, 64'd6);

    // Status load in EXEC, live ZZ, SL ignored in FETCH.
    fetch(32'h0000_0005);
    PS = 2'b00; SL = 1'b1; alu_status = 4'b1010;
    step();
    chk("sl_exec", {59'd0, status}, {59'd0, 5'b10100});
    SL = 1'b0; alu_status = 4'b0001;
    #1;
    chk("zz_live_1", {59'd0, status}, {59'd0, 5'b10101});
    alu_status = 4'b0000;
    #1;
    chk("zz_live_0", {59'd0, status}, {59'd0, 5'b10100});
    PS = 2'b01;
    step();
    chk("pc_58", pc, 64'h58);
    halt = 1'b1; SL = 1'b1; alu_status = 4'b0101;
    step();
    chk("sl_fetch_ignored", {59'd0, status}, {59'd0, 5'b10101});
    SL = 1'b0; halt = 1'b0; alu_status = 4'b0000;
    #1;

    // Wrap at the top of the address space.
    fetch(32'h0000_0006);
    PS = 2'b10; K = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h0000_0007);
    PS = 2'b01;
    step();
    chk("wrap_pc", pc, 64'h0);
    chk("wrap_cnt", {32'd0, instr_count}, 64'd9);

    // Halt during EXEC completes the instruction, then no request.
    fetch(32'h0000_0008);
    halt = 1'b1; PS = 2'b01;
    step();
    chk("halt_exec_pc", pc, 64'h4);
    chk("halt_exec_req", {63'd0, imem_req}, 64'd0);
    halt = 1'b0;
    #1;

    // Asynchronous reset in the middle of EXEC at pc 0x80.
    PS = 2'b10; K = 64'h80;
    fetch(32'h0000_0009);
    step();
    chk("pre_rst_pc", pc, 64'h80);
    fetch(32'h0000_000A);
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", pc, 64'h0);
    chk("arst_valid", {63'd0, instr_valid}, 64'd0);
    chk("arst_ir", {32'd0, instruction}, 64'd0);
    chk("arst_cnt", {32'd0, instr_count}, 64'd0);
    chk("arst_status", {59'd0, status}, 64'd0);
    chk("arst_req", {63'd0, imem_req}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
